// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues one word fetch at a
// time over a req/gnt/rvalid handshake, and buffers {pc, word} pairs in a
// small prefetch FIFO for decode. Redirects flush the FIFO and discard any
// response still in flight for the old path.
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_req_pc;
  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_valid;
  logic          w_grant;
  logic          w_push;
  logic          w_pop;
  logic [63:0]   w_head;
  logic          w_unused_bits;

  // Word alignment of the redirect target is forced, so its low bits never matter.
  assign w_unused_bits = &{1'b0, redirect_pc[1:0]};

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_valid   = !reset && (r_count != '0);
  assign imem_req  = !reset && (r_state == IDLE) && !w_full && !redirect;
  assign imem_addr = reset ? RESET_PC : r_fetch_pc;
  assign w_grant   = imem_req && imem_gnt;
  // A redirect voids both the same-cycle response and the same-cycle pop.
  assign w_push    = !reset && !redirect && (r_state == WAIT) && imem_rvalid;
  assign w_pop     = w_valid && instr_ready && !redirect;

  assign w_head      = r_mem[r_rd_ptr];
  assign instr_valid = w_valid;
  assign instr       = w_valid ? w_head[31:0]  : '0;
  assign instr_pc    = w_valid ? w_head[63:32] : '0;

  // Request-tracking FSM: next state from grant, response and redirect.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_grant) w_state_nxt = WAIT;
      WAIT: begin
        if (imem_rvalid)   w_state_nxt = IDLE;
        else if (redirect) w_state_nxt = DROP;
      end
      DROP: if (imem_rvalid) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Fetch PC, in-flight PC, FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (redirect) begin
      r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      r_rd_ptr   <= r_wr_ptr;
      r_count    <= '0;
    end else begin
      if (w_grant) begin
        r_req_pc   <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage: returned word tagged with the PC it was fetched from.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_req_pc, imem_rdata};
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Two instances share the clock: index 0 with
// RESET_PC=0 for most scenarios, index 1 with RESET_PC=FFFF_FFF8 for PC wrap.
// Each instance gets a small memory responder whose returned word is
// addr ^ 32'hA5A5_0000, with bench-controlled grant gating and rvalid delay.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  gnt_allow;
  int unsigned rv_delay [2];
  int unsigned n_pass;
  int unsigned n_total;
  int unsigned nreq;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        reset, req, gnt, rvalid, redirect, ready, valid;
    logic [31:0] addr, rdata, rpc, instr, ipc;

    fetch_unit #(
      .DEPTH    (4),
      .RESET_PC ((g == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (req),
      .imem_addr   (addr),
      .imem_gnt    (gnt),
      .imem_rvalid (rvalid),
      .imem_rdata  (rdata),
      .redirect    (redirect),
      .redirect_pc (rpc),
      .instr_valid (valid),
      .instr_ready (ready),
      .instr       (instr),
      .instr_pc    (ipc)
    );

    // Memory responder: grants while allowed, returns data rv_delay cycles later.
    initial begin : mem
      int unsigned cd;
      logic        fired;
      logic [31:0] alat;
      gnt = 1'b0; rvalid = 1'b0; rdata = '0;
      cd = 0; fired = 1'b0; alat = '0;
      forever begin
        @(negedge clk);
        #1;
        if (fired) cd = rv_delay[g];
        rvalid = 1'b0;
        if (cd != 0) begin
          cd = cd - 1;
          if (cd == 0) begin
            rvalid = 1'b1;
            rdata  = alat ^ 32'hA5A5_0000;
          end
        end
        gnt   = req & gnt_allow[g];
        fired = gnt;
        if (gnt) alat = addr;
      end
    end
  end

  task automatic tick(input logic rst, input logic rd, input logic rdr, input logic [31:0] tgt);
    @(negedge clk);
    g_dut[0].reset    = rst;
    g_dut[1].reset    = rst;
    g_dut[0].ready    = rd;
    g_dut[0].redirect = rdr;
    g_dut[0].rpc      = tgt;
    #3;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  initial begin
    n_pass = 0; n_total = 0; nreq = 0;
    gnt_allow = 2'b11;
    rv_delay[0] = 1; rv_delay[1] = 1;
    g_dut[0].reset = 1'b1; g_dut[0].ready = 1'b1; g_dut[0].redirect = 1'b0; g_dut[0].rpc = '0;
    g_dut[1].reset = 1'b1; g_dut[1].ready = 1'b1; g_dut[1].redirect = 1'b0; g_dut[1].rpc = '0;

    // Reset state, then streaming fetch with immediate grant and rvalid +1.
    tick(1, 1, 0, 0); tick(1, 1, 0, 0);
    chk("rst_req",   32'(g_dut[0].req),   0);
    chk("rst_addr",  g_dut[0].addr,       0);
    chk("rst_valid", 32'(g_dut[0].valid), 0);
    chk("rst_instr", g_dut[0].instr,      0);
    chk("rst_pc",    g_dut[0].ipc,        0);
    chk("rst_addr_hi", g_dut[1].addr, 32'hFFFF_FFF8);
    for (int k = 0; k < 10; k++) begin
      tick(0, 1, 0, 0);
      if (k == 0) begin
        chk("t1_req0",  32'(g_dut[0].req), 1);
        chk("t1_addr0", g_dut[0].addr, 0);
      end
      if (k < 2) begin
        chk("t1_early_valid", 32'(g_dut[0].valid), 0);
      end else if (k % 2 == 0) begin
        chk("t1_valid",   32'(g_dut[0].valid), 1);
        chk("t1_pc",      g_dut[0].ipc,   32'(4 * (k / 2 - 1)));
        chk("t1_instr",   g_dut[0].instr, 32'(4 * (k / 2 - 1)) ^ 32'hA5A5_0000);
        chk("wrap_valid", 32'(g_dut[1].valid), 1);
        chk("wrap_pc",    g_dut[1].ipc,   32'hFFFF_FFF8 + 32'(4 * (k / 2 - 1)));
        chk("wrap_instr", g_dut[1].instr, (32'hFFFF_FFF8 + 32'(4 * (k / 2 - 1))) ^ 32'hA5A5_0000);
      end else begin
        chk("t1_gap_valid", 32'(g_dut[0].valid), 0);
      end
    end

    // Decode stalled: FIFO fills to DEPTH and fetching stops, then drains in order.
    tick(1, 0, 0, 0); tick(1, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      tick(0, 0, 0, 0);
      if (g_dut[0].req && g_dut[0].gnt) nreq++;
    end
    chk("t2_nreq",     nreq, 4);
    chk("t2_req_full", 32'(g_dut[0].req), 0);
    chk("t2_addr",     g_dut[0].addr, 32'h10);
    chk("t2_head_pc",  g_dut[0].ipc,  0);
    for (int k = 0; k < 5; k++) begin
      tick(0, 1, 0, 0);
      chk("t2_drain_valid", 32'(g_dut[0].valid), 1);
      chk("t2_drain_pc",    g_dut[0].ipc, 32'(4 * k));
      if (k == 1) begin
        chk("t2_resume_req",  32'(g_dut[0].req), 1);
        chk("t2_resume_addr", g_dut[0].addr, 32'h10);
      end
    end

    // Grant withheld three cycles: request and address hold steady.
    tick(1, 1, 0, 0); tick(1, 1, 0, 0);
    gnt_allow[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 0, 0);
      chk("t3_stall_req",  32'(g_dut[0].req), 1);
      chk("t3_stall_addr", g_dut[0].addr, 0);
    end
    gnt_allow[0] = 1'b1;
    tick(0, 1, 0, 0);
    chk("t3_gnt_addr", g_dut[0].addr, 0);
    tick(0, 1, 0, 0);
    chk("t3_post_req",  32'(g_dut[0].req), 0);
    chk("t3_post_addr", g_dut[0].addr, 32'h4);
    tick(0, 1, 0, 0);
    chk("t3_pc", g_dut[0].ipc, 0);

    // Redirect while waiting; stale response two cycles later is dropped.
    tick(1, 1, 0, 0); tick(1, 1, 0, 0);
    rv_delay[0] = 3;
    tick(0, 1, 0, 0);
    chk("t4_req", 32'(g_dut[0].req), 1);
    tick(0, 1, 1, 32'h0000_0103);
    chk("t4_redir_req", 32'(g_dut[0].req), 0);
    tick(0, 1, 0, 0);
    chk("t4_drop_valid", 32'(g_dut[0].valid), 0);
    chk("t4_drop_req",   32'(g_dut[0].req), 0);
    chk("t4_drop_addr",  g_dut[0].addr, 32'h100);
    tick(0, 1, 0, 0);
    chk("t4_stale_valid", 32'(g_dut[0].valid), 0);
    rv_delay[0] = 1;
    tick(0, 1, 0, 0);
    chk("t4_new_req",    32'(g_dut[0].req), 1);
    chk("t4_new_addr",   g_dut[0].addr, 32'h100);
    chk("t4_still_empty", 32'(g_dut[0].valid), 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    chk("t4_pc",    g_dut[0].ipc,   32'h100);
    chk("t4_instr", g_dut[0].instr, 32'hA5A5_0100);

    // Redirect coinciding with rvalid and a pop; then a redirect while idle.
    tick(1, 0, 0, 0); tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("t5_head_pc", g_dut[0].ipc,  0);
    chk("t5_req4",    g_dut[0].addr, 32'h4);
    tick(0, 1, 1, 32'h0000_0200);
    chk("t5_rv_now", 32'(g_dut[0].rvalid), 1);
    tick(0, 1, 0, 0);
    chk("t5_flushed", 32'(g_dut[0].valid), 0);
    chk("t5_req",     32'(g_dut[0].req), 1);
    chk("t5_addr",    g_dut[0].addr, 32'h200);
    tick(0, 1, 0, 0);
    tick(0, 0, 1, 32'h0000_0300);
    chk("t5_pc",        g_dut[0].ipc, 32'h200);
    chk("t5_idle_supp", 32'(g_dut[0].req), 0);
    tick(0, 0, 0, 0);
    chk("t5_flush2", 32'(g_dut[0].valid), 0);
    chk("t5_addr2",  g_dut[0].addr, 32'h300);

    // Reset mid-WAIT: outputs clear, late rvalid ignored, restart at RESET_PC.
    tick(1, 1, 0, 0); tick(1, 1, 0, 0);
    rv_delay[0] = 3;
    tick(0, 1, 0, 0);
    chk("t7_req", 32'(g_dut[0].req), 1);
    tick(1, 1, 0, 0);
    chk("t7_rst_req",   32'(g_dut[0].req), 0);
    chk("t7_rst_addr",  g_dut[0].addr, 0);
    chk("t7_rst_valid", 32'(g_dut[0].valid), 0);
    gnt_allow[0] = 1'b0;
    tick(0, 1, 0, 0);
    chk("t7_restart_addr", g_dut[0].addr, 0);
    tick(0, 1, 0, 0);
    gnt_allow[0] = 1'b1;
    rv_delay[0] = 1;
    tick(0, 1, 0, 0);
    chk("t7_late_ignored", 32'(g_dut[0].valid), 0);
    chk("t7_req2",  32'(g_dut[0].req), 1);
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    chk("t7_pc",    g_dut[0].ipc,   0);
    chk("t7_instr", g_dut[0].instr, 32'hA5A5_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
